// File: rtl/ib_lut_ram_loader_pkg.sv
// rtl/ib_lut_ram_loader_pkg.sv - shared state encoding, geometry helpers and packing order for the LUT RAM loader
package ib_lut_ram_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    // First accepted symbol of a page lands in bank0, which sits in the word MSBs.
    localparam bit BANK0_MSB = 1'b1;

    function automatic int frm_w_of(input int multi_frame_num);
        return (multi_frame_num > 1) ? $clog2(multi_frame_num) : 1;
    endfunction

    function automatic int page_num_of(input int entry_addr, input int frm_w);
        return 2 ** (entry_addr - frm_w);
    endfunction

endpackage

// File: rtl/ib_lut_ram_loader_if.sv
// rtl/ib_lut_ram_loader_if.sv - symbol stream and RAM write port bundle of the LUT RAM loader
interface ib_lut_ram_loader_if #(
    parameter int LUT_PORT_SIZE = 2,
    parameter int BANK_NUM      = 2,
    parameter int ENTRY_ADDR    = 4
);
    logic [LUT_PORT_SIZE-1:0]          sym_in;
    logic                              sym_valid;
    logic                              sym_ready;
    logic [ENTRY_ADDR-1:0]             page_addr_ram;
    logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_0;
    logic                              ib_ram_we;

    modport master (
        input  sym_in, sym_valid,
        output sym_ready, page_addr_ram, ram_write_data_0, ib_ram_we
    );

    modport slave (
        output sym_in, sym_valid,
        input  sym_ready, page_addr_ram, ram_write_data_0, ib_ram_we
    );
endinterface

// File: rtl/ib_lut_sym_packer.sv
// rtl/ib_lut_sym_packer.sv - shifts accepted LUT symbols into a BANK_NUM-wide word and flags word completion
module ib_lut_sym_packer
    import ib_lut_ram_loader_pkg::*;
#(
    parameter int LUT_PORT_SIZE = 2,
    parameter int BANK_NUM      = 2
) (
    input  logic                              write_clk,
    input  logic                              rstn,
    input  logic                              clear,
    input  logic                              accept,
    input  logic [LUT_PORT_SIZE-1:0]          sym_in,
    output logic                              word_valid,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0] word
);
    localparam int WORD_W = LUT_PORT_SIZE * BANK_NUM;
    localparam int PACK_W = WORD_W - LUT_PORT_SIZE;
    localparam int CNT_W  = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

    logic [CNT_W-1:0]  bank_cnt;
    logic [PACK_W-1:0] pack_q;
    logic [WORD_W-1:0] next_pack;
    logic              last_bank;

    // pack_q only keeps the symbols already received; the word completes combinationally
    // with the current symbol so the top can register it on the same edge.
    generate
        if (BANK0_MSB) begin : g_msb_first
            assign next_pack = {pack_q, sym_in};
        end else begin : g_lsb_first
            assign next_pack = {sym_in, pack_q};
        end
    endgenerate

    assign last_bank  = (bank_cnt == CNT_W'(BANK_NUM - 1));
    assign word_valid = accept && last_bank;
    assign word       = next_pack;

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            bank_cnt <= '0;
            pack_q   <= '0;
        end else if (clear) begin
            bank_cnt <= '0;
            pack_q   <= '0;
        end else if (accept) begin
            pack_q   <= BANK0_MSB ? next_pack[PACK_W-1:0] : next_pack[WORD_W-1:LUT_PORT_SIZE];
            bank_cnt <= last_bank ? '0 : bank_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ib_lut_ram_loader.sv
// rtl/ib_lut_ram_loader.sv - LUT RAM write sequencer: packs symbols, writes one page per word for a frame
// Optional build macro IB_LOAD_CHECKSUM_EN adds an XOR checksum over written words.
module ib_lut_ram_loader
    import ib_lut_ram_loader_pkg::*;
#(
    parameter int LUT_PORT_SIZE   = 2,
    parameter int BANK_NUM        = 2,
    parameter int ENTRY_ADDR      = 4,
    parameter int MULTI_FRAME_NUM = 2,
    localparam int FRM_W          = frm_w_of(MULTI_FRAME_NUM),
    localparam int WORD_W         = LUT_PORT_SIZE * BANK_NUM
) (
    input  logic              write_clk,
    input  logic              rstn,
    input  logic              load_start,
    input  logic [FRM_W-1:0]  load_frame,
    input  logic              load_abort,
`ifdef IB_LOAD_CHECKSUM_EN
    input  logic [WORD_W-1:0] load_csum_exp,
    output logic              load_csum_err,
`endif
    ib_lut_ram_loader_if.master ram_if,
    output logic              load_busy,
    output logic              load_done
);
    localparam int PAGE_NUM = page_num_of(ENTRY_ADDR, FRM_W);
    localparam int PG_W     = ENTRY_ADDR - FRM_W;

    load_state_t       state;
    logic [FRM_W-1:0]  frame_q;
    logic [PG_W-1:0]   page_cnt;
    logic              accept;
    logic              pack_clear;
    logic              word_valid;
    logic [WORD_W-1:0] word;
`ifdef IB_LOAD_CHECKSUM_EN
    logic [WORD_W-1:0] csum_acc;
    logic [WORD_W-1:0] csum_exp_q;
`endif

    assign accept     = ram_if.sym_valid && ram_if.sym_ready;
    assign pack_clear = load_abort || (state != ST_FILL);

    ib_lut_sym_packer #(
        .LUT_PORT_SIZE (LUT_PORT_SIZE),
        .BANK_NUM      (BANK_NUM)
    ) u_packer (
        .write_clk  (write_clk),
        .rstn       (rstn),
        .clear      (pack_clear),
        .accept     (accept),
        .sym_in     (ram_if.sym_in),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state                   <= ST_IDLE;
            frame_q                 <= '0;
            page_cnt                <= '0;
            ram_if.sym_ready        <= 1'b0;
            ram_if.page_addr_ram    <= '0;
            ram_if.ram_write_data_0 <= '0;
            ram_if.ib_ram_we        <= 1'b0;
            load_busy               <= 1'b0;
            load_done               <= 1'b0;
`ifdef IB_LOAD_CHECKSUM_EN
            csum_acc                <= '0;
            csum_exp_q              <= '0;
            load_csum_err           <= 1'b0;
`endif
        end else begin
            ram_if.ib_ram_we <= 1'b0;
            load_done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!load_abort && load_start) begin
                        state            <= ST_FILL;
                        frame_q          <= load_frame;
                        page_cnt         <= '0;
                        ram_if.sym_ready <= 1'b1;
                        load_busy        <= 1'b1;
`ifdef IB_LOAD_CHECKSUM_EN
                        csum_acc         <= '0;
                        csum_exp_q       <= load_csum_exp;
                        load_csum_err    <= 1'b0;
`endif
                    end
                end
                ST_FILL: begin
                    if (load_abort) begin
                        state            <= ST_IDLE;
                        page_cnt         <= '0;
                        ram_if.sym_ready <= 1'b0;
                        load_busy        <= 1'b0;
                    end else if (word_valid) begin
                        ram_if.ram_write_data_0 <= word;
                        ram_if.page_addr_ram    <= {frame_q, page_cnt};
                        ram_if.ib_ram_we        <= 1'b1;
`ifdef IB_LOAD_CHECKSUM_EN
                        csum_acc                <= csum_acc ^ word;
`endif
                        // The last page closes the load; the counter never wraps inside FILL.
                        if (page_cnt == PG_W'(PAGE_NUM - 1)) begin
                            state            <= ST_DONE;
                            page_cnt         <= '0;
                            ram_if.sym_ready <= 1'b0;
                        end else begin
                            page_cnt <= page_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    load_busy <= 1'b0;
                    if (!load_abort) begin
                        load_done <= 1'b1;
`ifdef IB_LOAD_CHECKSUM_EN
                        load_csum_err <= (csum_acc != csum_exp_q);
`endif
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    ram_if.sym_ready <= 1'b0;
                    load_busy        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ib_lut_ram_loader.sv
// tb/tb_ib_lut_ram_loader.sv - self-checking bench for ib_lut_ram_loader against a page/word reference model
module tb_ib_lut_ram_loader;
    logic       write_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       load_start = 1'b0;
    logic       load_abort = 1'b0;
    logic [0:0] load_frame = 1'b0;
    logic       load_busy;
    logic       load_done;
`ifdef IB_LOAD_CHECKSUM_EN
    logic [3:0] load_csum_exp = 4'h0;
    logic       load_csum_err;
    logic       csum_err_exp = 1'b0;
`endif

    ib_lut_ram_loader_if #(.LUT_PORT_SIZE(2), .BANK_NUM(2), .ENTRY_ADDR(4)) ib ();

    ib_lut_ram_loader #(
        .LUT_PORT_SIZE   (2),
        .BANK_NUM        (2),
        .ENTRY_ADDR      (4),
        .MULTI_FRAME_NUM (2)
    ) dut (
        .write_clk     (write_clk),
        .rstn          (rstn),
        .load_start    (load_start),
        .load_frame    (load_frame),
        .load_abort    (load_abort),
`ifdef IB_LOAD_CHECKSUM_EN
        .load_csum_exp (load_csum_exp),
        .load_csum_err (load_csum_err),
`endif
        .ram_if        (ib.master),
        .load_busy     (load_busy),
        .load_done     (load_done)
    );

    always #5 write_clk = ~write_clk;

    int cyc = 0;
    always @(posedge write_clk) cyc++;

    int         we_cyc[$];
    int         done_cyc[$];
    logic [3:0] we_addr[$];
    logic [3:0] we_data[$];

    always @(negedge write_clk) begin
        if (ib.ib_ram_we === 1'b1) begin
            we_cyc.push_back(cyc);
            we_addr.push_back(ib.page_addr_ram);
            we_data.push_back(ib.ram_write_data_0);
        end
        if (load_done === 1'b1) done_cyc.push_back(cyc);
    end

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] syms[16];
    int fed = 0;
    int h0 = 0;
    int hl = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        we_cyc.delete();
        done_cyc.delete();
        we_addr.delete();
        we_data.delete();
        fed = 0;
    endtask

    task automatic fill_syms(input bit pattern);
        for (int i = 0; i < 16; i++)
            syms[i] = pattern ? 2'(i % 4) : 2'($urandom_range(3, 0));
    endtask

    function automatic logic [3:0] model_word(input int p);
        return 4'(int'(syms[2*p]) * 4 + int'(syms[2*p+1]));
    endfunction

`ifdef IB_LOAD_CHECKSUM_EN
    task automatic set_exp(input bit corrupt);
        logic [3:0] x = 4'h0;
        for (int p = 0; p < 8; p++) x = x ^ model_word(p);
        load_csum_exp = corrupt ? (x ^ 4'h5) : x;
        csum_err_exp  = corrupt;
    endtask
`endif

    task automatic start_load(input logic f);
        load_frame = f;
        load_start = 1'b1;
        @(posedge write_clk); #1;
        load_start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gapped);
        int got = 0;
        int budget = n * 4 + 8;
        bit tog = 1'b1;
        bit hs;
        int c;
        while (got < n && budget > 0) begin
            ib.sym_valid = gapped ? tog : 1'b1;
            ib.sym_in    = syms[fed];
            tog          = ~tog;
            @(negedge write_clk);
            hs = ib.sym_valid && (ib.sym_ready === 1'b1);
            c  = cyc;
            @(posedge write_clk); #1;
            if (hs) begin
                if (fed == 0) h0 = c;
                hl = c;
                fed++;
                got++;
            end
            budget--;
        end
        ib.sym_valid = 1'b0;
        check("feed_handshakes", got, n);
    endtask

    task automatic check_writes(input logic f, input int npg, input string tag);
        check({tag, "_count"}, we_addr.size(), npg);
        for (int p = 0; p < npg && p < we_addr.size(); p++) begin
            check({tag, "_addr"}, we_addr[p], int'(f) * 8 + p);
            check({tag, "_data"}, we_data[p], model_word(p));
        end
    endtask

    task automatic check_end();
        @(negedge write_clk);
        check("done_cyc_we", ib.ib_ram_we, 1);
        check("done_cyc_ready", ib.sym_ready, 0);
        check("done_cyc_busy", load_busy, 1);
        check("done_cyc_done", load_done, 0);
        @(negedge write_clk);
        check("done_pulse", load_done, 1);
        check("done_busy", load_busy, 0);
`ifdef IB_LOAD_CHECKSUM_EN
        check("csum_err", load_csum_err, csum_err_exp);
`endif
        @(negedge write_clk);
        check("done_single", load_done, 0);
        check("done_count", done_cyc.size(), 1);
        check("done_timing", (done_cyc.size() > 0) ? done_cyc[0] : -1, hl + 2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, ib.sym_ready, 0);
        check({tag, "_we"}, ib.ib_ram_we, 0);
        check({tag, "_addr"}, ib.page_addr_ram, 0);
        check({tag, "_data"}, ib.ram_write_data_0, 0);
        check({tag, "_busy"}, load_busy, 0);
        check({tag, "_done"}, load_done, 0);
`ifdef IB_LOAD_CHECKSUM_EN
        check({tag, "_csum"}, load_csum_err, 0);
`endif
    endtask

    initial begin
        logic f;
        int rdy_hi;
        ib.sym_valid = 1'b0;
        ib.sym_in    = 2'b00;

        // reset state
        repeat (3) @(posedge write_clk);
        #1;
        check_zero("reset");
        rstn = 1'b1;

        // idle with sym_valid held high: nothing consumed, nothing written
        clr();
        ib.sym_valid = 1'b1;
        rdy_hi = 0;
        repeat (20) begin
            @(negedge write_clk);
            if (ib.sym_ready !== 1'b0 || load_busy !== 1'b0) rdy_hi++;
        end
        ib.sym_valid = 1'b0;
        check("idle_ready_busy", rdy_hi, 0);
        check("idle_writes", we_addr.size(), 0);
        @(posedge write_clk); #1;

        // continuous 0,1,2,3 pattern into frame 1
        fill_syms(1'b1);
        clr();
`ifdef IB_LOAD_CHECKSUM_EN
        set_exp(1'b0);
`endif
        start_load(1'b1);
        feed(16, 1'b0);
        check_end();
        check_writes(1'b1, 8, "cont");
        for (int k = 0; k < 8 && k < we_cyc.size(); k++)
            check("cont_we_timing", we_cyc[k], h0 + 2 + 2 * k);

        // gapped random stream into frame 0
        fill_syms(1'b0);
        clr();
`ifdef IB_LOAD_CHECKSUM_EN
        set_exp(1'b1);
`endif
        start_load(1'b0);
        feed(16, 1'b1);
        check_end();
        check_writes(1'b0, 8, "gap");
`ifdef IB_LOAD_CHECKSUM_EN
        repeat (5) @(negedge write_clk);
        check("csum_err_held", load_csum_err, 1);
`endif

        // abort and start together in IDLE: abort wins
        @(posedge write_clk); #1;
        load_abort = 1'b1;
        load_start = 1'b1;
        @(posedge write_clk); #1;
        load_abort = 1'b0;
        load_start = 1'b0;
        @(negedge write_clk);
        check("abort_start_busy", load_busy, 0);
        check("abort_start_ready", ib.sym_ready, 0);

        // start while busy ignored, abort after 5 symbols
        f = 1'($urandom_range(1, 0));
        fill_syms(1'b0);
        clr();
`ifdef IB_LOAD_CHECKSUM_EN
        set_exp(1'b0);
`endif
        @(posedge write_clk); #1;
        start_load(f);
`ifdef IB_LOAD_CHECKSUM_EN
        check("csum_err_cleared", load_csum_err, 0);
`endif
        feed(3, 1'b0);
        load_start = 1'b1;
        load_frame = ~f;
        feed(2, 1'b0);
        load_start = 1'b0;
        load_abort = 1'b1;
        ib.sym_valid = 1'b1;
        ib.sym_in = syms[5];
        @(posedge write_clk); #1;
        load_abort = 1'b0;
        ib.sym_valid = 1'b0;
        repeat (6) @(negedge write_clk);
        check_writes(f, 2, "abort");
        check("abort_no_done", done_cyc.size(), 0);
        check("abort_busy", load_busy, 0);
        check("abort_ready", ib.sym_ready, 0);

        // next load after abort begins at page 0
        f = 1'($urandom_range(1, 0));
        fill_syms(1'b0);
        clr();
`ifdef IB_LOAD_CHECKSUM_EN
        set_exp(1'b0);
`endif
        @(posedge write_clk); #1;
        start_load(f);
        feed(16, 1'b0);
        check_end();
        check_writes(f, 8, "post_abort");

        // reset asserted after 3 writes
        f = 1'($urandom_range(1, 0));
        fill_syms(1'b0);
        clr();
        @(posedge write_clk); #1;
        start_load(f);
        feed(7, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("midrst");
        check_writes(f, 3, "prerst");
        @(posedge write_clk); #1;
        rstn = 1'b1;

        // load after reset starts from page 0
        f = 1'($urandom_range(1, 0));
        fill_syms(1'b0);
        clr();
`ifdef IB_LOAD_CHECKSUM_EN
        set_exp(1'b0);
`endif
        @(posedge write_clk); #1;
        start_load(f);
        feed(16, 1'b0);
        check_end();
        check_writes(f, 8, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
